// File: rtl/gate_quiz_ctrl_pkg.sv
// Shared definitions for the gate quiz controller: FSM states, gate-op codes
// and the LFSR step used to choose the next hidden gate.
package gate_quiz_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_PLAY,
        ST_BLANK,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_NAND    = 3'd2,
        OP_NOR     = 3'd3,
        OP_XOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_IMPLY   = 3'd6,
        OP_INHIBIT = 3'd7
    } gate_op_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;

    // x^8 + x^6 + x^5 + x^4 + 1, maximal length, so a nonzero seed never reaches zero
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/gate_op_eval.sv
// Combinational evaluator for the eight two-input gate operations the quiz
// can hide behind the player's operands.
module gate_op_eval
    import gate_quiz_ctrl_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (gate_op_t'(op))
            OP_AND:     y = a & b;
            OP_OR:      y = a | b;
            OP_NAND:    y = ~(a & b);
            OP_NOR:     y = ~(a | b);
            OP_XOR:     y = a ^ b;
            OP_XNOR:    y = ~(a ^ b);
            OP_IMPLY:   y = ~a | b;
            OP_INHIBIT: y = a & ~b;
            default:    y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_quiz_ctrl.sv
// Gate-guessing game controller: hides one of NUM_GATES logic gates, lets the
// player probe it through in1/in2, and scores one-hot guesses with a miss penalty.
module gate_quiz_ctrl
    import gate_quiz_ctrl_pkg::*;
#(
    parameter int NUM_GATES    = 8,
    parameter int BLANK_CYCLES = 50_000_000
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in1,
    input  logic                 in2,
    input  logic                 switch_select,
    input  logic                 confirm_select,
    output logic                 outwire,
    output logic [NUM_GATES-1:0] selected_gate,
    output logic [NUM_GATES-1:0] current_gate,
    output logic [NUM_GATES-1:0] completed_gate,
    output logic                 timer_en,
    output logic                 vga_blankout,
    output logic [7:0]           miss_count,
    output logic                 round_done
);

    localparam int                   BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0]        BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [NUM_GATES-1:0] FULL_MASK  = '1;
    localparam logic [2:0]           LAST_IDX   = 3'(NUM_GATES - 1);

    state_t               state, state_n;
    logic                 start_q, switch_q, confirm_q;
    logic                 start_ev, switch_ev, confirm_ev;
    logic [7:0]           lfsr;
    logic [2:0]           scan_idx, scan_idx_n;
    logic [2:0]           cur_idx, cur_idx_n;
    logic                 cur_valid, cur_valid_n;
    logic [NUM_GATES-1:0] sel_n, done_n;
    logic [7:0]           miss_n;
    logic [BW-1:0]        blank_cnt, blank_cnt_n;
    logic [7:0]           done_pad;
    logic [2:0]           pick_start;
    logic                 op_y;

    assign start_ev   = start & ~start_q;
    assign switch_ev  = switch_select & ~switch_q;
    assign confirm_ev = confirm_select & ~confirm_q;

    assign done_pad   = 8'(completed_gate);
    assign pick_start = 3'(lfsr % 8'(NUM_GATES));

    assign current_gate = cur_valid ? NUM_GATES'(8'b1 << cur_idx) : '0;
    assign timer_en     = (state == ST_PICK) || (state == ST_PLAY) || (state == ST_BLANK);
    assign vga_blankout = (state == ST_BLANK);
    assign round_done   = (state == ST_DONE);

    gate_op_eval u_op (
        .op (cur_idx),
        .a  (in1),
        .b  (in2),
        .y  (op_y)
    );

    always_comb begin
        state_n     = state;
        scan_idx_n  = scan_idx;
        cur_idx_n   = cur_idx;
        cur_valid_n = cur_valid;
        sel_n       = selected_gate;
        done_n      = completed_gate;
        miss_n      = miss_count;
        blank_cnt_n = blank_cnt;

        // Rotation uses the registered selection, so a same-cycle confirm is judged pre-rotation
        if (switch_ev && (state == ST_PLAY || state == ST_BLANK)) begin
            sel_n = {selected_gate[NUM_GATES-2:0], selected_gate[NUM_GATES-1]};
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ev) begin
                    state_n     = ST_PICK;
                    done_n      = '0;
                    miss_n      = '0;
                    sel_n       = NUM_GATES'(1);
                    cur_valid_n = 1'b0;
                    scan_idx_n  = pick_start;
                end
            end
            ST_PICK: begin
                if (!done_pad[scan_idx]) begin
                    cur_idx_n   = scan_idx;
                    cur_valid_n = 1'b1;
                    state_n     = ST_PLAY;
                end else begin
                    scan_idx_n = (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
                end
            end
            ST_PLAY: begin
                if (confirm_ev) begin
                    if (selected_gate == current_gate) begin
                        done_n      = completed_gate | current_gate;
                        cur_valid_n = 1'b0;
                        if (done_n == FULL_MASK) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n    = ST_PICK;
                            scan_idx_n = pick_start;
                        end
                    end else begin
                        if (miss_count != 8'hFF) begin
                            miss_n = miss_count + 8'd1;
                        end
                        blank_cnt_n = '0;
                        state_n     = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_n = ST_PLAY;
                end else begin
                    blank_cnt_n = blank_cnt + BW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Edge registers reset high so a level already asserted at reset release is not an event
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            start_q        <= 1'b1;
            switch_q       <= 1'b1;
            confirm_q      <= 1'b1;
            lfsr           <= LFSR_SEED;
            scan_idx       <= '0;
            cur_idx        <= '0;
            cur_valid      <= 1'b0;
            selected_gate  <= NUM_GATES'(1);
            completed_gate <= '0;
            miss_count     <= '0;
            blank_cnt      <= '0;
            outwire        <= 1'b0;
        end else begin
            state          <= state_n;
            start_q        <= start;
            switch_q       <= switch_select;
            confirm_q      <= confirm_select;
            lfsr           <= lfsr_next(lfsr);
            scan_idx       <= scan_idx_n;
            cur_idx        <= cur_idx_n;
            cur_valid      <= cur_valid_n;
            selected_gate  <= sel_n;
            completed_gate <= done_n;
            miss_count     <= miss_n;
            blank_cnt      <= blank_cnt_n;
            outwire        <= (cur_valid && state != ST_BLANK) ? op_y : 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_quiz_ctrl.sv
// Randomized self-checking bench for gate_quiz_ctrl: a 4-gate instance for the
// game flow and an 8-gate instance for the full op table.
module tb_gate_quiz_ctrl;

    localparam int N     = 4;
    localparam int BLANK = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, in1 = 1'b0, in2 = 1'b0;
    logic       switch_select = 1'b0, confirm_select = 1'b0;
    logic       outwire, timer_en, vga_blankout, round_done;
    logic [N-1:0] selected_gate, current_gate, completed_gate;
    logic [7:0] miss_count;

    logic       start8 = 1'b0, switch8 = 1'b0, confirm8 = 1'b0;
    logic       outwire8, timer_en8, vga8, done8;
    logic [7:0] sel8, cur8, comp8, miss8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int snap = 0;

    logic [N-1:0] m_done;
    int m_sel, m_cur, m_miss;

    // Truth table per op, indexed by {a,b}
    logic [3:0] truth [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                              4'b0110, 4'b1001, 4'b1011, 4'b0100};

    gate_quiz_ctrl #(.NUM_GATES(N), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
        .switch_select(switch_select), .confirm_select(confirm_select),
        .outwire(outwire), .selected_gate(selected_gate), .current_gate(current_gate),
        .completed_gate(completed_gate), .timer_en(timer_en), .vga_blankout(vga_blankout),
        .miss_count(miss_count), .round_done(round_done)
    );

    gate_quiz_ctrl #(.NUM_GATES(8), .BLANK_CYCLES(3)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .in1(in1), .in2(in2),
        .switch_select(switch8), .confirm_select(confirm8),
        .outwire(outwire8), .selected_gate(sel8), .current_gate(cur8),
        .completed_gate(comp8), .timer_en(timer_en8), .vga_blankout(vga8),
        .miss_count(miss8), .round_done(done8)
    );

    always #5 clk = ~clk;

    // Non-reset edges since reset: the LFSR has stepped exactly this many times
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] l;
        l = 8'h01;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    function automatic int pick_idx(input int n, input int ng, input logic [7:0] done);
        int s;
        s = int'(lfsr_at(n)) % ng;
        for (int k = 0; k < ng; k++) begin
            if (!done[3'((s + k) % ng)]) return (s + k) % ng;
        end
        return -1;
    endfunction

    task automatic pulse_start();
        start = 1'b1; snap = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_confirm();
        confirm_select = 1'b1; snap = cyc;
        @(negedge clk);
        confirm_select = 1'b0;
    endtask

    task automatic pulse_switch();
        switch_select = 1'b1;
        @(negedge clk);
        switch_select = 1'b0;
        @(negedge clk);
        m_sel = (m_sel + 1) % N;
    endtask

    task automatic rotate_to(input int target);
        for (int k = 0; k < N && m_sel != target; k++) pulse_switch();
    endtask

    task automatic wait_pick(input string tag);
        int s, exp_idx, exp_wait, waited;
        s        = int'(lfsr_at(snap)) % N;
        exp_idx  = pick_idx(snap, N, 8'(m_done));
        exp_wait = ((exp_idx - s + N) % N) + 1;
        waited   = 0;
        while (current_gate == '0 && waited < N + 2) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (current_gate !== N'(1 << exp_idx) || waited != exp_wait) begin
            errors++;
            $display("[TB] FAIL %s: current_gate=%b after %0d cycles, required %b after %0d cycles",
                     tag, current_gate, waited, N'(1 << exp_idx), exp_wait);
        end
        m_cur = exp_idx;
    endtask

    task automatic sweep_outwire(input int op);
        int base, p;
        base = int'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            p = (i < 4) ? (base + i) % 4 : int'($urandom_range(0, 3));
            in1 = p[1]; in2 = p[0];
            @(negedge clk);
            checks++;
            if (outwire !== truth[3'(op)][p[1:0]]) begin
                errors++;
                $display("[TB] FAIL outwire op%0d in=%0d%0d: got %b, required %b",
                         op, p[1], p[0], outwire, truth[3'(op)][p[1:0]]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (selected_gate !== 4'b0001 || current_gate !== 4'b0000 || completed_gate !== 4'b0000 ||
            miss_count !== 8'd0 || outwire !== 1'b0 || timer_en !== 1'b0 ||
            vga_blankout !== 1'b0 || round_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: sel=%b cur=%b comp=%b miss=%0d out=%b timer=%b blank=%b done=%b, required sel=0001 and all else 0",
                     selected_gate, current_gate, completed_gate, miss_count, outwire, timer_en, vga_blankout, round_done);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (timer_en !== 1'b0 || current_gate !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL held_start_no_event: timer_en=%b cur=%b, required 0 and 0000", timer_en, current_gate);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_pick();
        m_done = '0; m_sel = 0; m_miss = 0;
        pulse_start();
        checks++;
        if (timer_en !== 1'b1 || current_gate !== 4'b0000 || selected_gate !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL start_to_pick: timer_en=%b cur=%b sel=%b, required 1 0000 0001",
                     timer_en, current_gate, selected_gate);
        end
        wait_pick("first_pick");
    endtask

    task automatic test_full_round();
        for (int j = 0; j < N; j++) begin
            if (j > 0) wait_pick("next_pick");
            sweep_outwire(m_cur);
            rotate_to(m_cur);
            if (j == 1) begin
                switch_select = 1'b1; confirm_select = 1'b1; snap = cyc;
                @(negedge clk);
                switch_select = 1'b0; confirm_select = 1'b0;
                m_sel = (m_sel + 1) % N;
            end else begin
                pulse_confirm();
            end
            m_done[2'(m_cur)] = 1'b1;
            checks++;
            if (completed_gate !== m_done || selected_gate !== N'(1 << m_sel) || miss_count !== 8'd0) begin
                errors++;
                $display("[TB] FAIL correct_confirm %0d: comp=%b sel=%b miss=%0d, required comp=%b sel=%b miss=0",
                         j, completed_gate, selected_gate, miss_count, m_done, N'(1 << m_sel));
            end
        end
        checks++;
        if (completed_gate !== 4'hF || round_done !== 1'b1 || timer_en !== 1'b0 ||
            miss_count !== 8'd0 || current_gate !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL round_complete: comp=%h done=%b timer=%b miss=%0d cur=%b, required F 1 0 0 0000",
                     completed_gate, round_done, timer_en, miss_count, current_gate);
        end
    endtask

    task automatic test_switch();
        pulse_start();
        m_done = '0; m_sel = 0; m_miss = 0;
        checks++;
        if (completed_gate !== 4'b0000 || miss_count !== 8'd0 || selected_gate !== 4'b0001 ||
            timer_en !== 1'b1 || round_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_from_done: comp=%b miss=%0d sel=%b timer=%b done=%b, required 0000 0 0001 1 0",
                     completed_gate, miss_count, selected_gate, timer_en, round_done);
        end
        wait_pick("round2_pick");
        switch_select = 1'b1;
        repeat (20) @(negedge clk);
        switch_select = 1'b0;
        checks++;
        if (selected_gate !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL switch_held: sel=%b, required 0010", selected_gate);
        end
        m_sel = 1;
        @(negedge clk);
        rotate_to(3);
        checks++;
        if (selected_gate !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rotate_to_top: sel=%b, required 1000", selected_gate);
        end
        pulse_switch();
        checks++;
        if (selected_gate !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rotate_wrap: sel=%b, required 0001", selected_gate);
        end
    endtask

    task automatic test_start_ignored();
        pulse_start();
        @(negedge clk);
        checks++;
        if (current_gate !== N'(1 << m_cur) || timer_en !== 1'b1 || completed_gate !== 4'b0000 ||
            selected_gate !== N'(1 << m_sel)) begin
            errors++;
            $display("[TB] FAIL start_in_play: cur=%b timer=%b comp=%b sel=%b, required cur=%b 1 0000 sel=%b",
                     current_gate, timer_en, completed_gate, selected_gate, N'(1 << m_cur), N'(1 << m_sel));
        end
    endtask

    task automatic test_blank();
        int wrong, p, high;
        wrong = (m_cur + int'($urandom_range(1, N - 1))) % N;
        rotate_to(wrong);
        p = 0;
        while (p < 3 && truth[3'(m_cur)][p[1:0]] == 1'b0) p++;
        in1 = p[1]; in2 = p[0];
        pulse_confirm();
        m_miss++;
        checks++;
        if (vga_blankout !== 1'b1 || miss_count !== 8'(m_miss) || current_gate !== N'(1 << m_cur) || timer_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrong_confirm: blank=%b miss=%0d cur=%b timer=%b, required 1 %0d %b 1",
                     vga_blankout, miss_count, current_gate, timer_en, m_miss, N'(1 << m_cur));
        end
        high = 0;
        for (int i = 0; i < 3 * BLANK && vga_blankout === 1'b1; i++) begin
            high++;
            if (i == 1) begin
                checks++;
                if (outwire !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL outwire_in_blank: got %b, required 0", outwire);
                end
            end
            switch_select  = (i == 2);
            confirm_select = (i == 4);
            @(negedge clk);
        end
        switch_select = 1'b0; confirm_select = 1'b0;
        m_sel = (m_sel + 1) % N;
        checks++;
        if (high != BLANK) begin
            errors++;
            $display("[TB] FAIL blank_length: high for %0d cycles, required %0d", high, BLANK);
        end
        checks++;
        if (vga_blankout !== 1'b0 || timer_en !== 1'b1 || current_gate !== N'(1 << m_cur) ||
            miss_count !== 8'(m_miss) || selected_gate !== N'(1 << m_sel)) begin
            errors++;
            $display("[TB] FAIL after_blank: blank=%b timer=%b cur=%b miss=%0d sel=%b, required 0 1 %b %0d %b",
                     vga_blankout, timer_en, current_gate, miss_count, selected_gate,
                     N'(1 << m_cur), m_miss, N'(1 << m_sel));
        end
    endtask

    task automatic test_reset_mid_blank();
        int wrong;
        wrong = (m_sel == m_cur) ? (m_cur + 1) % N : m_sel;
        rotate_to(wrong);
        pulse_confirm();
        repeat ($urandom_range(1, 7)) @(negedge clk);
        checks++;
        if (vga_blankout !== 1'b1 || miss_count !== 8'(m_miss + 1)) begin
            errors++;
            $display("[TB] FAIL second_miss: blank=%b miss=%0d, required 1 %0d", vga_blankout, miss_count, m_miss + 1);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (selected_gate !== 4'b0001 || current_gate !== 4'b0000 || completed_gate !== 4'b0000 ||
            miss_count !== 8'd0 || outwire !== 1'b0 || timer_en !== 1'b0 ||
            vga_blankout !== 1'b0 || round_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_blank: sel=%b cur=%b comp=%b miss=%0d out=%b timer=%b blank=%b done=%b, required sel=0001 and all else 0",
                     selected_gate, current_gate, completed_gate, miss_count, outwire, timer_en, vga_blankout, round_done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_op_table();
        logic [7:0] done_m;
        int sel_m, cur, waited, base, p;
        done_m = '0; sel_m = 0;
        start8 = 1'b1; snap = cyc;
        @(negedge clk);
        start8 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cur = pick_idx(snap, 8, done_m);
            waited = 0;
            while (cur8 == 8'd0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (cur8 !== 8'(1 << cur)) begin
                errors++;
                $display("[TB] FAIL pick8 %0d: cur=%b, required %b", j, cur8, 8'(1 << cur));
            end
            base = int'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                p = (base + i) % 4;
                in1 = p[1]; in2 = p[0];
                @(negedge clk);
                checks++;
                if (outwire8 !== truth[3'(cur)][p[1:0]]) begin
                    errors++;
                    $display("[TB] FAIL op_table op%0d in=%0d%0d: got %b, required %b",
                             cur, p[1], p[0], outwire8, truth[3'(cur)][p[1:0]]);
                end
            end
            for (int k = 0; k < 8 && sel_m != cur; k++) begin
                switch8 = 1'b1;
                @(negedge clk);
                switch8 = 1'b0;
                @(negedge clk);
                sel_m = (sel_m + 1) % 8;
            end
            confirm8 = 1'b1; snap = cyc;
            @(negedge clk);
            confirm8 = 1'b0;
            done_m[3'(cur)] = 1'b1;
        end
        checks++;
        if (comp8 !== 8'hFF || done8 !== 1'b1 || timer_en8 !== 1'b0 || miss8 !== 8'd0 || vga8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL round8_complete: comp=%h done=%b timer=%b miss=%0d blank=%b, required FF 1 0 0 0",
                     comp8, done8, timer_en8, miss8, vga8);
        end
    endtask

    initial begin
        test_reset();
        test_start_pick();
        test_full_round();
        test_switch();
        test_start_ignored();
        test_blank();
        test_reset_mid_blank();
        test_op_table();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_quiz_ctrl.md
GATE_QUIZ_CTRL -- requirements
Module: gate_quiz_ctrl

Interface
REQ-001 SHALL have parameter NUM_GATES, default 8, number of gates in play (legal 2..8).
REQ-002 SHALL have parameter BLANK_CYCLES, default 50_000_000, miss-penalty duration in clk cycles (legal >= 1).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-005 SHALL have port start, input, 1, level; its rising edge begins a round.
REQ-006 SHALL have ports in1 and in2, inputs, 1 each, player operands applied to the hidden gate.
REQ-007 SHALL have port switch_select, input, 1, level; its rising edge advances the selection.
REQ-008 SHALL have port confirm_select, input, 1, level; its rising edge submits the guess.
REQ-009 SHALL have port outwire, output, 1, registered result of the hidden gate on in1 and in2.
REQ-010 SHALL have port selected_gate, output, NUM_GATES, one-hot player selection.
REQ-011 SHALL have port current_gate, output, NUM_GATES, one-hot hidden gate, or zero when none is active.
REQ-012 SHALL have port completed_gate, output, NUM_GATES, mask of gates already identified.
REQ-013 SHALL have port timer_en, output, 1, high while a round is in progress.
REQ-014 SHALL have port vga_blankout, output, 1, high during the miss penalty.
REQ-015 SHALL have port miss_count, output, 8, number of misses this round, saturating at 255.
REQ-016 SHALL have port round_done, output, 1, high once every gate is completed.

Function
REQ-017 SHALL edge-detect start, switch_select and confirm_select with one register each; a held level yields exactly one event.
REQ-018 SHALL implement states IDLE, PICK, PLAY, BLANK and DONE.
REQ-019 SHALL, on a start event in IDLE or DONE, clear completed_gate and miss_count, set selected_gate to bit 0, and enter PICK.
REQ-020 SHALL run an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01, never zero) that advances on every cycle.
REQ-021 SHALL, on PICK entry, latch scan index = lfsr mod NUM_GATES, then test one index per cycle, wrapping from NUM_GATES-1 to 0; the first uncompleted index becomes current_gate and the state goes to PLAY, so PICK takes at most NUM_GATES cycles.
REQ-022 SHALL, on a switch event in PLAY or BLANK, rotate selected_gate left by one position, with bit NUM_GATES-1 wrapping to bit 0.
REQ-023 SHALL, on a confirm event in PLAY where selected_gate equals current_gate, OR current_gate into completed_gate and go to DONE if the mask becomes full, otherwise to PICK.
REQ-024 SHALL, on a confirm event in PLAY with a mismatch (including selecting an already-completed gate), increment miss_count (saturating) and enter BLANK.
REQ-025 SHALL hold vga_blankout high for exactly BLANK_CYCLES cycles in BLANK, then return to PLAY with current_gate unchanged.
REQ-026 SHALL ignore confirm events in IDLE, PICK, BLANK and DONE, and ignore start events in PICK, PLAY and BLANK.
REQ-027 SHALL, when switch and confirm events occur in the same cycle, judge the confirm against the pre-rotation selection and also apply the rotation.
REQ-028 SHALL compute outwire one cycle after in1/in2 using the op for the current_gate index: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 (~in1|in2), 7 (in1&~in2).
REQ-029 SHALL drive outwire to 0 when current_gate is zero or the state is BLANK.
REQ-030 SHALL drive timer_en high in PICK, PLAY and BLANK only.
REQ-031 SHALL drive round_done high in DONE only.

Reset
REQ-032 SHALL, on reset, set state to IDLE, selected_gate to 1, current_gate, completed_gate and miss_count to 0, and outwire, timer_en, vga_blankout and round_done to 0.
REQ-033 SHALL, on reset, set the LFSR to 8'h01, clear the blank counter, and load the edge-detect registers with 1 so a held input produces no event.
REQ-034 SHALL give reset priority over every event, including mid-BLANK and mid-PICK.

Structure
REQ-035 SHALL take state encodings and the gate-op codes 0..7 from a shared package.
REQ-036 SHALL implement the op table as sub-module gate_op_eval (inputs: op index, a, b; output: y).

Verification
REQ-037 SHALL cover: NUM_GATES=4; reset, then start pulse -> timer_en=1 and current_gate one-hot within 4 cycles of PICK entry.
REQ-038 SHALL cover: correct confirm four times -> completed_gate=4'hF, round_done=1, timer_en=0, miss_count=0.
REQ-039 SHALL cover: BLANK_CYCLES=10, wrong confirm -> vga_blankout high for exactly 10 cycles, miss_count=1, current_gate unchanged.
REQ-040 SHALL cover: switch held high for 20 cycles -> exactly one rotation (4'b0001 -> 4'b0010); rotation from 4'b1000 wraps to 4'b0001.
REQ-041 SHALL cover: sweep in1/in2 over 00/01/10/11 for each op index -> outwire matches the REQ-028 table one cycle later.
REQ-042 SHALL cover: reset asserted mid-BLANK -> all outputs equal their REQ-032 values on the next cycle.
